// File: rtl/signal_scheduler.sv
// rtl/signal_scheduler.sv - turn/brake signal mode scheduler with brake preemption and turn resume
module signal_scheduler #(
    parameter int TURN_S  = 10,
    parameter int BRAKE_S = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_all,
    input  logic       tick_1s,
    input  logic       req_left,
    input  logic       req_right,
    input  logic       req_brake,
    output logic [1:0] state,
    output logic [3:0] remaining,
    output logic       resume_pending,
    output logic       done
);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        BRAKE  = 2'b11
    } state_t;

    localparam logic [3:0] TURN_LOAD  = 4'(TURN_S);
    localparam logic [3:0] BRAKE_LOAD = 4'(BRAKE_S);

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    state_t     saved_q, saved_d;
    logic [3:0] saved_rem_q, saved_rem_d;
    logic       pend_q, pend_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NORMAL;
            rem_q       <= 4'd0;
            saved_q     <= NORMAL;
            saved_rem_q <= 4'd0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            saved_q     <= saved_d;
            saved_rem_q <= saved_rem_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        saved_d     = saved_q;
        saved_rem_d = saved_rem_q;
        pend_d      = pend_q;
        done_d      = 1'b0;

        if (!en_all) begin
            state_d     = NORMAL;
            rem_d       = 4'd0;
            saved_d     = NORMAL;
            saved_rem_d = 4'd0;
            pend_d      = 1'b0;
        end else if (req_brake) begin
            // Entering brake from a turn parks the turn with its time frozen
            if (state_q == LEFT || state_q == RIGHT) begin
                saved_d     = state_q;
                saved_rem_d = rem_q;
                pend_d      = 1'b1;
            end else if (state_q == NORMAL) begin
                pend_d = 1'b0;
            end
            state_d = BRAKE;
            rem_d   = BRAKE_LOAD;
        end else if (req_right || req_left) begin
            if (state_q == BRAKE) begin
                saved_d     = req_right ? RIGHT : LEFT;
                saved_rem_d = TURN_LOAD;
                pend_d      = 1'b1;
            end else begin
                state_d = req_right ? RIGHT : LEFT;
                rem_d   = TURN_LOAD;
            end
        end else if (tick_1s && state_q != NORMAL && rem_q != 4'd0) begin
            if (rem_q == 4'd1) begin
                done_d = 1'b1;
                pend_d = 1'b0;
                if (state_q == BRAKE && pend_q) begin
                    state_d = saved_q;
                    rem_d   = saved_rem_q;
                end else begin
                    state_d = NORMAL;
                    rem_d   = 4'd0;
                end
            end else begin
                rem_d = rem_q - 4'd1;
            end
        end
    end

    assign state          = state_q;
    assign remaining      = rem_q;
    assign resume_pending = pend_q;
    assign done           = done_q;

endmodule

// File: tb/tb_signal_scheduler.sv
// tb/tb_signal_scheduler.sv - self-checking bench for signal_scheduler against a behavioural model
module tb_signal_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_all = 1'b0;
    logic       tick_1s = 1'b0;
    logic       req_left = 1'b0;
    logic       req_right = 1'b0;
    logic       req_brake = 1'b0;
    logic [1:0] state;
    logic [3:0] remaining;
    logic       resume_pending;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 normal, 1 left, 2 right, 3 brake
    int m_mode, m_rem, m_saved_mode, m_saved_rem, m_pend, m_done;

    signal_scheduler #(.TURN_S(10), .BRAKE_S(5)) dut (
        .clk(clk), .rst(rst), .en_all(en_all), .tick_1s(tick_1s),
        .req_left(req_left), .req_right(req_right), .req_brake(req_brake),
        .state(state), .remaining(remaining),
        .resume_pending(resume_pending), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_rem = 0; m_saved_mode = 0; m_saved_rem = 0; m_pend = 0; m_done = 0;
    endfunction

    function automatic void model_step(input bit en, input bit tk, input bit l, input bit r, input bit b);
        m_done = 0;
        if (!en) begin
            model_reset();
        end else if (b) begin
            if (m_mode == 1 || m_mode == 2) begin
                m_saved_mode = m_mode; m_saved_rem = m_rem; m_pend = 1;
            end
            m_mode = 3; m_rem = 5;
        end else if (l || r) begin
            if (m_mode == 3) begin
                m_saved_mode = r ? 2 : 1; m_saved_rem = 10; m_pend = 1;
            end else begin
                m_mode = r ? 2 : 1; m_rem = 10;
            end
        end else if (tk && m_mode != 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_done = 1;
                if (m_mode == 3 && m_pend == 1) begin
                    m_mode = m_saved_mode; m_rem = m_saved_rem;
                end else begin
                    m_mode = 0;
                end
                m_pend = 0;
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".state"}, int'(state), m_mode);
        check({tag, ".remaining"}, int'(remaining), m_rem);
        check({tag, ".pending"}, int'(resume_pending), m_pend);
        check({tag, ".done"}, int'(done), m_done);
    endtask

    task automatic expect_out(input string tag, input int st, input int rm, input int pd, input int dn);
        check({tag, ".st"}, int'(state), st);
        check({tag, ".rem"}, int'(remaining), rm);
        check({tag, ".pend"}, int'(resume_pending), pd);
        check({tag, ".done"}, int'(done), dn);
    endtask

    task automatic step(input string tag, input bit en, input bit tk, input bit l, input bit r, input bit b);
        en_all = en; tick_1s = tk; req_left = l; req_right = r; req_brake = b;
        @(posedge clk);
        model_step(en, tk, l, r, b);
        #1;
        compare_model(tag);
    endtask

    initial begin
        model_reset();
        #12;
        expect_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Left turn runs ten ticks then expires with a single done
        step("l_req", 1, 0, 1, 0, 0);
        expect_out("l_start", 1, 10, 0, 0);
        for (int i = 9; i >= 1; i--) begin
            step("l_tick", 1, 1, 0, 0, 0);
            check("l_rem", int'(remaining), i);
        end
        step("l_last", 1, 1, 0, 0, 0);
        expect_out("l_expire", 0, 0, 0, 1);
        step("l_after", 1, 0, 0, 0, 0);
        check("l_done_once", int'(done), 0);

        // Right preempted by brake, then resumed at saved time
        step("r_req", 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("r_tick", 1, 1, 0, 0, 0);
        check("r_rem7", int'(remaining), 7);
        step("rb_req", 1, 0, 0, 0, 1);
        expect_out("rb_start", 3, 5, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            step("rb_tick", 1, 1, 0, 0, 0);
            check("rb_rem", int'(remaining), i);
        end
        step("rb_last", 1, 1, 0, 0, 0);
        expect_out("rb_resume", 2, 7, 0, 1);
        for (int i = 0; i < 7; i++) step("r_drain", 1, 1, 0, 0, 0);
        check("r_drained", int'(state), 0);

        // Brake + right + tick together from normal
        step("combo", 1, 1, 0, 1, 1);
        expect_out("combo", 3, 5, 0, 0);
        for (int i = 0; i < 5; i++) step("combo_drain", 1, 1, 0, 0, 0);
        check("combo_normal", int'(state), 0);

        // Saved left at 4 overwritten by right request during brake
        step("sv_l", 1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step("sv_tick", 1, 1, 0, 0, 0);
        check("sv_rem4", int'(remaining), 4);
        step("sv_brake", 1, 0, 0, 0, 1);
        step("sv_right", 1, 0, 0, 1, 0);
        expect_out("sv_right", 3, 5, 1, 0);
        for (int i = 0; i < 5; i++) step("sv_btick", 1, 1, 0, 0, 0);
        expect_out("sv_resume", 2, 10, 0, 1);

        // Disable during left at 6; requests ignored while low
        step("dis_l", 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step("dis_tick", 1, 1, 0, 0, 0);
        check("dis_rem6", int'(remaining), 6);
        step("dis_off", 0, 0, 0, 0, 0);
        expect_out("dis_off", 0, 0, 0, 0);
        step("dis_req", 0, 1, 1, 0, 0);
        expect_out("dis_req", 0, 0, 0, 0);
        step("dis_on", 1, 0, 0, 0, 0);
        expect_out("dis_on", 0, 0, 0, 0);

        // Async reset mid-right
        step("rs_r", 1, 0, 0, 1, 0);
        step("rs_tick", 1, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        expect_out("rs_async", 0, 0, 0, 0);
        #1 rst = 1'b0;
        step("rs_left", 1, 0, 1, 0, 0);
        expect_out("rs_left", 1, 10, 0, 0);

        // Randomized traffic against the model, occasional async reset
        for (int n = 0; n < 3000; n++) begin
            bit en, tk, l, r, b;
            en = ($urandom_range(0, 39) != 0);
            tk = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 24) == 0);
            r  = ($urandom_range(0, 24) == 0);
            b  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                compare_model("rnd_rst");
                #1 rst = 1'b0;
            end
            step("rnd", en, tk, l, r, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
